ei_axi4_mux_interconnect: RTL

EI_AXI4_MUX_INTERCONNECT -- requirements
Module: ei_axi4_mux_interconnect

---
 rtl/ei_axi4_mux_interconnect.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/ei_axi4_mux_interconnect.sv
// N-to-1 AXI4 interconnect: round-robin arbitration with independent write and read owners.
// The grant is registered, so a request reaches the slave one cycle after it is first seen.
module ei_axi4_mux_interconnect #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    // Master-side write address
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_awaddr,
    input  logic [NUM_MASTERS*2-1:0]            m_awburst,
    input  logic [NUM_MASTERS*8-1:0]            m_awlen,
    input  logic [NUM_MASTERS*3-1:0]            m_awsize,
    input  logic [NUM_MASTERS-1:0]              m_awvalid,
    output logic [NUM_MASTERS-1:0]              m_awready,
    // Master-side write data
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_wdata,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_wstrb,
    input  logic [NUM_MASTERS-1:0]              m_wlast,
    input  logic [NUM_MASTERS-1:0]              m_wvalid,
    output logic [NUM_MASTERS-1:0]              m_wready,
    // Master-side write response
    output logic [NUM_MASTERS*2-1:0]            m_bresp,
    output logic [NUM_MASTERS-1:0]              m_bvalid,
    input  logic [NUM_MASTERS-1:0]              m_bready,
    // Master-side read address
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_araddr,
    input  logic [NUM_MASTERS*2-1:0]            m_arburst,
    input  logic [NUM_MASTERS*8-1:0]            m_arlen,
    input  logic [NUM_MASTERS*3-1:0]            m_arsize,
    input  logic [NUM_MASTERS-1:0]              m_arvalid,
    output logic [NUM_MASTERS-1:0]              m_arready,
    // Master-side read data
    output logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_rdata,
    output logic [NUM_MASTERS*2-1:0]            m_rresp,
    output logic [NUM_MASTERS-1:0]              m_rlast,
    output logic [NUM_MASTERS-1:0]              m_rvalid,
    input  logic [NUM_MASTERS-1:0]              m_rready,
    // Slave side
    output logic [ADDR_WIDTH-1:0]               s_awaddr,
    output logic [1:0]                          s_awburst,
    output logic [7:0]                          s_awlen,
    output logic [2:0]                          s_awsize,
    output logic                                s_awvalid,
    input  logic                                s_awready,
    output logic [DATA_WIDTH-1:0]               s_wdata,
    output logic [DATA_WIDTH/8-1:0]             s_wstrb,
    output logic                                s_wlast,
    output logic                                s_wvalid,
    input  logic                                s_wready,
    input  logic [1:0]                          s_bresp,
    input  logic                                s_bvalid,
    output logic                                s_bready,
    output logic [ADDR_WIDTH-1:0]               s_araddr,
    output logic [1:0]                          s_arburst,
    output logic [7:0]                          s_arlen,
    output logic [2:0]                          s_arsize,
    output logic                                s_arvalid,
    input  logic                                s_arready,
    input  logic [DATA_WIDTH-1:0]               s_rdata,
    input  logic [1:0]                          s_rresp,
    input  logic                                s_rlast,
    input  logic                                s_rvalid,
    output logic                                s_rready,
    // Monitor taps
    output logic [NUM_MASTERS-1:0]              wr_grant,
    output logic [NUM_MASTERS-1:0]              rd_grant
);

    localparam int unsigned IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned SW = DATA_WIDTH / 8;

    typedef enum logic [1:0] {WIdle, WAddr, WData, WResp} wr_state_e;
    typedef enum logic [1:0] {RIdle, RAddr, RData} rd_state_e;

    // First requester at or after ptr, wrapping at NUM_MASTERS-1.
    function automatic logic [IW-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                              input logic [IW-1:0] ptr);
        logic [IW-1:0] pick;
        logic          found;
        int unsigned   idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            idx = (32'(ptr) + i) % NUM_MASTERS;
            if (!found && req[idx]) begin
                pick  = IW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] idx);
        return (32'(idx) == NUM_MASTERS - 1) ? '0 : idx + 1'b1;
    endfunction

    wr_state_e     wr_state_q, wr_state_d;
    rd_state_e     rd_state_q, rd_state_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d, wr_ptr_q, wr_ptr_d;
    logic [IW-1:0] rd_idx_q, rd_idx_d, rd_ptr_q, rd_ptr_d;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state_q <= WIdle;
            wr_idx_q   <= '0;
            wr_ptr_q   <= '0;
            rd_state_q <= RIdle;
            rd_idx_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_idx_q   <= wr_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_state_q <= rd_state_d;
            rd_idx_q   <= rd_idx_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Completion is decided by wlast/rlast alone; beats are never counted.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_idx_d   = wr_idx_q;
        wr_ptr_d   = wr_ptr_q;
        unique case (wr_state_q)
            WIdle: if (|m_awvalid) begin
                wr_idx_d   = rr_pick(m_awvalid, wr_ptr_q);
                wr_state_d = WAddr;
            end
            WAddr: if (s_awvalid && s_awready) wr_state_d = WData;
            WData: if (s_wvalid && s_wready && s_wlast) wr_state_d = WResp;
            WResp: if (s_bvalid && s_bready) begin
                wr_state_d = WIdle;
                wr_ptr_d   = ptr_inc(wr_idx_q);
            end
            default: wr_state_d = WIdle;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_idx_d   = rd_idx_q;
        rd_ptr_d   = rd_ptr_q;
        unique case (rd_state_q)
            RIdle: if (|m_arvalid) begin
                rd_idx_d   = rr_pick(m_arvalid, rd_ptr_q);
                rd_state_d = RAddr;
            end
            RAddr: if (s_arvalid && s_arready) rd_state_d = RData;
            RData: if (s_rvalid && s_rready && s_rlast) begin
                rd_state_d = RIdle;
                rd_ptr_d   = ptr_inc(rd_idx_q);
            end
            default: rd_state_d = RIdle;
        endcase
    end

    assign wr_grant = (wr_state_q != WIdle) ? (NUM_MASTERS'(1) << wr_idx_q) : '0;
    assign rd_grant = (rd_state_q != RIdle) ? (NUM_MASTERS'(1) << rd_idx_q) : '0;

    // Each channel is connected only during its own phase; W beats are refused in WAddr.
    always_comb begin
        s_awaddr  = '0;
        s_awburst = '0;
        s_awlen   = '0;
        s_awsize  = '0;
        s_awvalid = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wlast   = 1'b0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        m_awready = '0;
        m_wready  = '0;
        m_bvalid  = '0;
        m_bresp   = '0;
        unique case (wr_state_q)
            WAddr: begin
                s_awaddr  = m_awaddr[wr_idx_q*ADDR_WIDTH +: ADDR_WIDTH];
                s_awburst = m_awburst[wr_idx_q*2 +: 2];
                s_awlen   = m_awlen[wr_idx_q*8 +: 8];
                s_awsize  = m_awsize[wr_idx_q*3 +: 3];
                s_awvalid = m_awvalid[wr_idx_q];
                m_awready[wr_idx_q] = s_awready;
            end
            WData: begin
                s_wdata  = m_wdata[wr_idx_q*DATA_WIDTH +: DATA_WIDTH];
                s_wstrb  = m_wstrb[wr_idx_q*SW +: SW];
                s_wlast  = m_wlast[wr_idx_q];
                s_wvalid = m_wvalid[wr_idx_q];
                m_wready[wr_idx_q] = s_wready;
            end
            WResp: begin
                s_bready = m_bready[wr_idx_q];
                m_bvalid[wr_idx_q] = s_bvalid;
                m_bresp[wr_idx_q*2 +: 2] = s_bresp;
            end
            default: ;
        endcase
    end

    always_comb begin
        s_araddr  = '0;
        s_arburst = '0;
        s_arlen   = '0;
        s_arsize  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        m_arready = '0;
        m_rvalid  = '0;
        m_rlast   = '0;
        m_rdata   = '0;
        m_rresp   = '0;
        unique case (rd_state_q)
            RAddr: begin
                s_araddr  = m_araddr[rd_idx_q*ADDR_WIDTH +: ADDR_WIDTH];
                s_arburst = m_arburst[rd_idx_q*2 +: 2];
                s_arlen   = m_arlen[rd_idx_q*8 +: 8];
                s_arsize  = m_arsize[rd_idx_q*3 +: 3];
                s_arvalid = m_arvalid[rd_idx_q];
                m_arready[rd_idx_q] = s_arready;
            end
            RData: begin
                s_rready = m_rready[rd_idx_q];
                m_rvalid[rd_idx_q] = s_rvalid;
                m_rlast[rd_idx_q]  = s_rlast;
                m_rdata[rd_idx_q*DATA_WIDTH +: DATA_WIDTH] = s_rdata;
                m_rresp[rd_idx_q*2 +: 2] = s_rresp;
            end
            default: ;
        endcase
    end

endmodule
